// File: rtl/fp_itof.sv
// Three-stage integer-to-float32 converter (signed or unsigned per transaction),
// round-to-nearest-even with inexact flag, valid/ready handshake on both sides.
module fp_itof #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] int_in,
  input  logic                  in_unsigned,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] float_result,
  output logic                  inexact
);

  if (DATA_WIDTH != 32) begin : g_width_check
    $fatal(1, "fp_itof: DATA_WIDTH must be 32");
  end

  function automatic logic [4:0] lead_zeros(input logic [31:0] v);
    logic [4:0] cnt;
    logic       found;
    cnt   = '0;
    found = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      cnt   = cnt + 5'd1;
      end
    end
    return cnt;
  endfunction

  // Returns {inexact, float}. The normalized leading one is implicit in norm.
  function automatic logic [32:0] round_pack(input logic        sign,
                                             input logic        zero,
                                             input logic [4:0]  p,
                                             input logic [30:0] norm);
    logic [22:0] frac;
    logic        guard;
    logic        sticky;
    logic        up;
    logic [7:0]  exp;
    logic [23:0] frac_r;
    frac   = norm[30:8];
    guard  = norm[7];
    sticky = |norm[6:0];
    up     = guard & (sticky | frac[0]);
    exp    = 8'd127 + {3'b000, p};
    frac_r = {1'b0, frac} + {23'd0, up};
    if (frac_r[23]) exp = exp + 8'd1;
    if (zero) return '0;
    return {guard | sticky, sign, exp, frac_r[22:0]};
  endfunction

  logic        stall;
  logic        adv;
  logic        vld_p0, vld_p1, vld_p2;

  logic        sign_p0, zero_p0;
  logic [31:0] mag_p0;
  logic        sign_p1, zero_p1;
  logic [4:0]  p_p1;
  logic [30:0] norm_p1;

  logic signed [31:0] int_s;
  logic        in_sign;
  logic [31:0] mag_next;
  logic [4:0]  lz;
  logic [30:0] norm_next;
  logic [32:0] packed_res;

  assign stall     = vld_p2 & ~out_ready;
  assign adv       = ~stall;
  assign in_ready  = adv;
  assign out_valid = vld_p2;

  assign int_s     = int_in;
  assign in_sign   = ~in_unsigned & int_in[31];
  assign mag_next  = in_sign ? 32'(-int_s) : int_in;

  assign lz        = lead_zeros(mag_p0);
  assign norm_next = mag_p0[30:0] << lz;

  assign packed_res = round_pack(sign_p1, zero_p1, p_p1, norm_p1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (adv) begin
      vld_p0 <= in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  always_ff @(posedge clk) begin
    // S1: capture, sign and magnitude
    if (adv && in_valid) begin
      sign_p0 <= in_sign;
      zero_p0 <= (mag_next == 32'd0);
      mag_p0  <= mag_next;
    end
    // S2: normalize so the leading one sits at bit 31
    if (adv && vld_p0) begin
      sign_p1 <= sign_p0;
      zero_p1 <= zero_p0;
      p_p1    <= 5'd31 - lz;
      norm_p1 <= norm_next;
    end
  end

  // S3: round, pack and present
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      float_result <= '0;
      inexact      <= 1'b0;
    end else if (adv && vld_p1) begin
      float_result <= packed_res[31:0];
      inexact      <= packed_res[32];
    end
  end

endmodule

// File: tb/tb_fp_itof.sv
// Directed bench for fp_itof: conversion values, rounding ties, handshake,
// bubbles and asynchronous reset with data in flight.
module tb_fp_itof;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] int_in;
  logic        in_unsigned;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] float_result;
  logic        inexact;

  int n_checks = 0;
  int n_fail   = 0;

  fp_itof #(.DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .int_in       (int_in),
    .in_unsigned  (in_unsigned),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .float_result (float_result),
    .inexact      (inexact)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; int_in = '0; in_unsigned = 1'b0; out_ready = 1'b1;
    repeat (2) tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++;
    if (float_result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 00000000", float_result); end
    n_checks++;
    if (inexact !== 1'b0) begin n_fail++; $display("FAIL reset_inexact: got %b want 0", inexact); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    rst = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] vin  [3] = '{32'd1, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] vexp [3] = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin in_valid = 1'b1; int_in = vin[i]; in_unsigned = 1'b0; end
      else in_valid = 1'b0;
      tick();
      if (i >= 2) begin
        n_checks++;
        if (out_valid !== 1'b1 || float_result !== vexp[i-2] || inexact !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b[%0d]: got v=%b %h ix=%b want v=1 %h ix=0", i-2, out_valid, float_result, inexact, vexp[i-2]);
        end
      end else begin
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_latency[%0d]: out_valid got %b want 0", i, out_valid); end
      end
    end
  endtask

  task automatic test_extremes;
    logic [31:0] vin  [6] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'd3};
    logic        vuns [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] vexp [6] = '{32'hCF00_0000, 32'h4F00_0000, 32'h4F80_0000, 32'h4F00_0000, 32'h3F80_0000, 32'h4040_0000};
    logic        vix  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    repeat (3) tick();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i < 6) begin in_valid = 1'b1; int_in = vin[i]; in_unsigned = vuns[i]; end
      else in_valid = 1'b0;
      tick();
      if (i >= 2) begin
        n_checks++;
        if (out_valid !== 1'b1 || float_result !== vexp[i-2] || inexact !== vix[i-2]) begin
          n_fail++;
          $display("FAIL extreme[%0d]: got v=%b %h ix=%b want v=1 %h ix=%b", i-2, out_valid, float_result, inexact, vexp[i-2], vix[i-2]);
        end
      end
    end
  endtask

  task automatic test_rne;
    logic [31:0] vin  [3] = '{32'd16777217, 32'd16777219, 32'd16777218};
    logic [31:0] vexp [3] = '{32'h4B80_0000, 32'h4B80_0002, 32'h4B80_0001};
    logic        vix  [3] = '{1'b1, 1'b1, 1'b0};
    repeat (3) tick();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin in_valid = 1'b1; int_in = vin[i]; in_unsigned = 1'b0; end
      else in_valid = 1'b0;
      tick();
      if (i >= 2) begin
        n_checks++;
        if (out_valid !== 1'b1 || float_result !== vexp[i-2] || inexact !== vix[i-2]) begin
          n_fail++;
          $display("FAIL rne[%0d]: got v=%b %h ix=%b want v=1 %h ix=%b", i-2, out_valid, float_result, inexact, vexp[i-2], vix[i-2]);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] vin  [5] = '{32'd10, 32'd11, 32'd12, 32'd13, 32'd14};
    logic [31:0] vexp [5] = '{32'h4120_0000, 32'h4130_0000, 32'h4140_0000, 32'h4150_0000, 32'h4160_0000};
    int          sent = 0;
    int          recv = 0;
    int          stall_cycles = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_res = '0;
    repeat (3) tick();
    in_unsigned = 1'b0;
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 4 && c <= 10);
      if (sent < 5) begin in_valid = 1'b1; int_in = vin[sent]; end
      else in_valid = 1'b0;
      #1;
      if (out_valid && !out_ready) begin
        stall_cycles++;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready c=%0d: got %b want 0", c, in_ready); end
        if (prev_stall) begin
          n_checks++;
          if (float_result !== prev_res) begin n_fail++; $display("FAIL bp_hold c=%0d: got %h want %h", c, float_result, prev_res); end
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (recv >= 5) begin
          n_fail++; $display("FAIL bp_extra c=%0d: got %h want no output", c, float_result);
        end else if (float_result !== vexp[recv]) begin
          n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", recv, float_result, vexp[recv]);
        end
        recv++;
      end
      if (in_valid && in_ready) sent++;
      prev_stall = out_valid & ~out_ready;
      prev_res   = float_result;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (recv !== 5) begin n_fail++; $display("FAIL bp_count: got %0d outputs want 5", recv); end
    n_checks++;
    if (stall_cycles < 6) begin n_fail++; $display("FAIL bp_stall_seen: got %0d stall cycles want >=6", stall_cycles); end
  endtask

  task automatic test_bubbles;
    logic [31:0] vin  [3] = '{32'd5, 32'd0, 32'd7};
    logic        vval [3] = '{1'b1, 1'b0, 1'b1};
    logic        evld [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    repeat (3) tick();
    out_ready = 1'b1;
    in_unsigned = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) begin in_valid = vval[i]; int_in = vin[i]; end
      else in_valid = 1'b0;
      tick();
      n_checks++;
      if (out_valid !== evld[i]) begin n_fail++; $display("FAIL bubble_valid[%0d]: got %b want %b", i, out_valid, evld[i]); end
      if (i == 2) begin
        n_checks++;
        if (float_result !== 32'h40A0_0000) begin n_fail++; $display("FAIL bubble_res0: got %h want 40a00000", float_result); end
      end
      if (i == 4) begin
        n_checks++;
        if (float_result !== 32'h40E0_0000) begin n_fail++; $display("FAIL bubble_res1: got %h want 40e00000", float_result); end
      end
    end
  endtask

  task automatic test_async_reset;
    repeat (3) tick();
    out_ready = 1'b1;
    in_unsigned = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; int_in = 32'(i + 1);
      tick();
    end
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ar_pre_valid: got %b want 1", out_valid); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || float_result !== 32'h0 || inexact !== 1'b0) begin
      n_fail++; $display("FAIL ar_immediate: got v=%b %h ix=%b want v=0 00000000 ix=0", out_valid, float_result, inexact);
    end
    #3 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_stale[%0d]: got out_valid %b want 0", i, out_valid); end
    end
    in_valid = 1'b1; int_in = 32'd6;
    for (int i = 0; i < 3; i++) begin
      tick();
      in_valid = 1'b0;
      if (i < 2) begin
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_latency[%0d]: got out_valid %b want 0", i, out_valid); end
      end
    end
    n_checks++;
    if (out_valid !== 1'b1 || float_result !== 32'h40C0_0000 || inexact !== 1'b0) begin
      n_fail++; $display("FAIL ar_new: got v=%b %h ix=%b want v=1 40c00000 ix=0", out_valid, float_result, inexact);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; int_in = '0; in_unsigned = 1'b0; out_ready = 1'b1;
    test_reset();
    test_back_to_back();
    test_extremes();
    test_rne();
    test_backpressure();
    test_bubbles();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
